// File: rtl/jk_pkg.sv
// Shared types and constants for the JK bank driver: FSM states, don't-care
// fill encodings and internal counter widths.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } jk_state_e;

  localparam int unsigned JK_DC_ZERO = 0;
  localparam int unsigned JK_DC_ONE  = 1;

  // SETTLE spans 1..15, MAX_RETRY spans 0..7
  localparam int unsigned SETTLE_CNT_W = 4;
  localparam int unsigned RETRY_CNT_W  = 3;

endpackage

// File: rtl/jk_excite.sv
// Per-bit JK excitation: J/K that move a flop from q to t in one clock, with
// don't-cares filled by DC_FILL (0: set/reset style, 1: toggle style).
module jk_excite
  import jk_pkg::*;
#(
  parameter int unsigned W       = 4,
  parameter int unsigned DC_FILL = JK_DC_ZERO
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] t,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  if (DC_FILL == JK_DC_ONE) begin : g_toggle
    assign j = (~q & t) | q;
    assign k = (q & ~t) | ~q;
  end else begin : g_set_reset
    assign j = ~q & t;
    assign k = q & ~t;
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a JK flop bank to a requested target word: one drive cycle, SETTLE
// hold cycles, then a check. Define JK_FB_CHECK_EN to enable feedback compare/retry/err.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int unsigned W         = 4,
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned DC_FILL   = JK_DC_ZERO
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_data,
  output logic         tgt_ready,
  output logic [W-1:0] J,
  output logic [W-1:0] K,
  input  logic [W-1:0] q_fb,
  output logic         done,
  output logic         err,
  output logic         busy
);

  jk_state_e               state;
  logic [W-1:0]            tgt_q;
  logic [SETTLE_CNT_W-1:0] settle_cnt;

  logic         accept_c;
  logic         pass_c;
  logic         retry_ok_c;
  logic [W-1:0] exc_tgt_c;
  logic [W-1:0] exc_j_c;
  logic [W-1:0] exc_k_c;

  assign accept_c = tgt_valid & tgt_ready;

  // J/K are loaded on the edge that enters DRIVE, so the target is taken
  // straight from the port on accept and from tgt_q on a retry.
  assign exc_tgt_c = accept_c ? tgt_data : tgt_q;

  jk_excite #(
    .W       (W),
    .DC_FILL (DC_FILL)
  ) u_excite (
    .q (q_fb),
    .t (exc_tgt_c),
    .j (exc_j_c),
    .k (exc_k_c)
  );

`ifdef JK_FB_CHECK_EN
  logic [RETRY_CNT_W-1:0] retry_cnt;

  assign pass_c     = (q_fb == tgt_q);
  assign retry_ok_c = (retry_cnt < RETRY_CNT_W'(MAX_RETRY));

  // Retry bookkeeping and sticky error, cleared by the next accepted target
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      retry_cnt <= '0;
      err       <= 1'b0;
    end else if (state == jk_pkg::IDLE && accept_c) begin
      retry_cnt <= '0;
      err       <= 1'b0;
    end else if (state == jk_pkg::CHECK && !pass_c) begin
      if (retry_ok_c) retry_cnt <= retry_cnt + RETRY_CNT_W'(1);
      else            err       <= 1'b1;
    end
  end
`else
  assign pass_c     = 1'b1;
  assign retry_ok_c = 1'b0;
  assign err        = 1'b0;
`endif

  // Main sequencer; J/K default to hold (0) in every cycle not entering DRIVE
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= jk_pkg::IDLE;
      tgt_q      <= '0;
      settle_cnt <= '0;
      J          <= '0;
      K          <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      tgt_ready  <= 1'b1;
    end else begin
      J    <= '0;
      K    <= '0;
      done <= 1'b0;
      unique case (state)
        jk_pkg::IDLE: begin
          if (accept_c) begin
            tgt_q     <= tgt_data;
            J         <= exc_j_c;
            K         <= exc_k_c;
            state     <= jk_pkg::DRIVE;
            busy      <= 1'b1;
            tgt_ready <= 1'b0;
          end
        end
        jk_pkg::DRIVE: begin
          settle_cnt <= SETTLE_CNT_W'(SETTLE);
          state      <= jk_pkg::SETTLE;
        end
        jk_pkg::SETTLE: begin
          if (settle_cnt <= SETTLE_CNT_W'(1)) state <= jk_pkg::CHECK;
          else settle_cnt <= settle_cnt - SETTLE_CNT_W'(1);
        end
        jk_pkg::CHECK: begin
          if (pass_c) begin
            done      <= 1'b1;
            state     <= jk_pkg::IDLE;
            busy      <= 1'b0;
            tgt_ready <= 1'b1;
          end else if (retry_ok_c) begin
            J     <= exc_j_c;
            K     <= exc_k_c;
            state <= jk_pkg::DRIVE;
          end else begin
            state     <= jk_pkg::IDLE;
            busy      <= 1'b0;
            tgt_ready <= 1'b1;
          end
        end
        default: state <= jk_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench for jk_bank_driver: two instances (set/reset and toggle fill)
// each drive a behavioural JK flop bank; expectations come from the excitation table.
module tb_jk_bank_driver;

  localparam int unsigned W         = 4;
  localparam int unsigned SETTLE    = 1;
  localparam int unsigned MAX_RETRY = 2;
`ifdef JK_FB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] start;
    bit           stuck;
    int           gap;
  } item_t;

  logic         CLK = 1'b0;
  logic         RST_n = 1'b0;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_data = '0;
  logic         rdy [2];
  logic         done [2];
  logic         err [2];
  logic         busy [2];
  logic [W-1:0] jv [2];
  logic [W-1:0] kv [2];
  logic [W-1:0] bank [2];
  logic [W-1:0] qfb [2];
  logic         stuck = 1'b0;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  item_t sb0[$];
  item_t sb1[$];

  always #5 CLK = ~CLK;

  jk_bank_driver #(.W(W), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY), .DC_FILL(0)) u_dut0 (
    .CLK(CLK), .RST_n(RST_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(rdy[0]), .J(jv[0]), .K(kv[0]), .q_fb(qfb[0]),
    .done(done[0]), .err(err[0]), .busy(busy[0]));

  jk_bank_driver #(.W(W), .SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY), .DC_FILL(1)) u_dut1 (
    .CLK(CLK), .RST_n(RST_n), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
    .tgt_ready(rdy[1]), .J(jv[1]), .K(kv[1]), .q_fb(qfb[1]),
    .done(done[1]), .err(err[1]), .busy(busy[1]));

  // Behavioural JK flop bank; stuck forces the observed Q to zero
  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < W; b++) begin
        if (preset_en) bank[i][b] <= preset_val[b];
        else begin
          case ({jv[i][b], kv[i][b]})
            2'b10:   bank[i][b] <= 1'b1;
            2'b01:   bank[i][b] <= 1'b0;
            2'b11:   bank[i][b] <= ~bank[i][b];
            default: bank[i][b] <= bank[i][b];
          endcase
        end
      end
    end
  end

  assign qfb[0] = stuck ? '0 : bank[0];
  assign qfb[1] = stuck ? '0 : bank[1];

  // Excitation table: hold/set/reset/hold-one with don't-cares set to fill
  function automatic logic [2*W-1:0] ref_jk(input logic [W-1:0] q, input logic [W-1:0] t,
                                            input logic fill);
    logic [W-1:0] j;
    logic [W-1:0] k;
    j = '0;
    k = '0;
    for (int b = 0; b < W; b++) begin
      case ({q[b], t[b]})
        2'b00:   begin j[b] = 1'b0; k[b] = fill; end
        2'b01:   begin j[b] = 1'b1; k[b] = fill; end
        2'b10:   begin j[b] = fill; k[b] = 1'b1; end
        default: begin j[b] = fill; k[b] = 1'b0; end
      endcase
    end
    return {j, k};
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Monitor: transaction starts when busy rises, ends when busy falls
  int    start_cyc [2];
  int    idle_cnt [2];
  int    nz_cnt [2];
  logic  pb [2];
  bit    have [2];
  item_t cur [2];

  always @(negedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic           fill;
      logic [2*W-1:0] ejk;
      bit             pass;
      int             att;
      int             qn;
      fill = (i == 1);
      if (!RST_n) begin
        pb[i]       = 1'b0;
        have[i]     = 1'b0;
        idle_cnt[i] = 0;
      end else begin
        if (busy[i] && !pb[i]) begin
          qn = (i == 0) ? sb0.size() : sb1.size();
          if (qn == 0) begin
            chk("unexpected_start", i, 1, 0);
            have[i] = 1'b0;
          end else begin
            cur[i]  = (i == 0) ? sb0[0] : sb1[0];
            have[i] = 1'b1;
            ejk = ref_jk(cur[i].start, cur[i].tgt, fill);
            chk("drive_jk", i, {jv[i], kv[i]}, ejk);
            chk("err_cleared", i, err[i], 0);
            if (cur[i].gap >= 0) chk("accept_gap", i, idle_cnt[i], cur[i].gap);
          end
          start_cyc[i] = cyc;
          nz_cnt[i]    = 0;
          idle_cnt[i]  = 0;
        end
        if (busy[i] && (jv[i] != '0 || kv[i] != '0)) nz_cnt[i]++;
        if (!busy[i] && pb[i]) begin
          if (have[i]) begin
            if (i == 0) void'(sb0.pop_front());
            else        void'(sb1.pop_front());
            pass = !CHK || !cur[i].stuck || (cur[i].tgt == '0);
            att  = pass ? 1 : 1 + MAX_RETRY;
            ejk  = ref_jk(cur[i].start, cur[i].tgt, fill);
            chk("done", i, done[i], pass);
            chk("err", i, err[i], !pass);
            chk("latency", i, cyc - start_cyc[i], att * (2 + SETTLE));
            chk("drive_count", i, nz_cnt[i], (ejk != '0) ? att : 0);
            chk("final_q", i, qfb[i], cur[i].stuck ? '0 : cur[i].tgt);
            chk("ready_at_end", i, rdy[i], 1);
            have[i] = 1'b0;
          end
        end else if (done[i]) begin
          chk("spurious_done", i, done[i], 0);
        end
        if (!busy[i]) begin
          chk("idle_jk", i, {jv[i], kv[i]}, 0);
          idle_cnt[i]++;
        end
        pb[i] = busy[i];
      end
    end
  end

  task automatic set_bank(input logic [W-1:0] v);
    @(negedge CLK);
    preset_val = v;
    preset_en  = 1'b1;
    @(posedge CLK);
    #1 preset_en = 1'b0;
  endtask

  // Offer a target until accepted; keep leaves valid high for a back-to-back offer
  task automatic send(input logic [W-1:0] t, input int gap, input bit keep);
    item_t it;
    bit    ok;
    int    n;
    ok = 1'b0;
    n  = 0;
    @(negedge CLK);
    tgt_valid = 1'b1;
    tgt_data  = t;
    while (!ok && n < 200) begin
      if (rdy[0] && rdy[1]) begin
        it.tgt = t; it.stuck = stuck; it.gap = gap;
        it.start = qfb[0]; sb0.push_back(it);
        it.start = qfb[1]; sb1.push_back(it);
        ok = 1'b1;
      end else begin
        @(negedge CLK);
        n++;
      end
    end
    chk("accept_in_time", 0, ok, 1);
    @(posedge CLK);
    if (!keep) #1 tgt_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 0, sb0.size() + sb1.size(), 0);
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit           hold;
    bit           nk;
    logic [W-1:0] t;
    RST_n      = 1'b0;
    preset_en  = 1'b1;
    preset_val = '0;
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", i, {rdy[i], busy[i], done[i], err[i], jv[i], kv[i]},
          {1'b1, 3'b000, 8'h00});
    @(negedge CLK);
    RST_n     = 1'b1;
    preset_en = 1'b0;

    set_bank(4'b0000); send(4'b1010, -1, 1'b0); drain();
    set_bank(4'b1100); send(4'b1010, -1, 1'b0); drain();
    set_bank(4'b0110); send(4'b0110, -1, 1'b0); drain();

    @(negedge CLK); stuck = 1'b1;
    send(4'b0001, -1, 1'b0); drain();
    stuck = 1'b0;
    set_bank(4'b0011); send(4'b0101, -1, 1'b0); drain();

    // New value offered while busy must wait for the first IDLE cycle
    set_bank(4'b0000);
    send(4'b1001, -1, 1'b1);
    send(4'b0110, 1, 1'b0);
    drain();

    // Reset during SETTLE aborts the transfer
    set_bank(4'b0000);
    send(4'b1111, -1, 1'b0);
    @(posedge CLK);
    #2 RST_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk("abort_outputs", i, {jv[i], kv[i], done[i], busy[i], rdy[i]}, {8'h00, 3'b001});
    sb0.delete();
    sb1.delete();
    @(posedge CLK);
    #2 RST_n = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++)
      chk("after_abort", i, {rdy[i], busy[i], done[i]}, 3'b100);

    hold = 1'b0;
    for (int n = 0; n < 30; n++) begin
      t = W'($urandom);
      if (!hold) begin
        drain();
        if ($urandom_range(0, 1) == 1) set_bank(W'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      nk = (n != 29) && ($urandom_range(0, 2) == 0);
      send(t, hold ? 1 : -1, nk);
      hold = nk;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Drives the J/K inputs of a bank of W JK flip-flops so that the bank reaches a requested target word.
- Computes per-bit J/K from the JK excitation table, using the flops' Q outputs as the current state.
- Holds the drive for exactly one clock, waits for the outputs to settle, then confirms the result and retries if needed.
- Sits between a control FSM (valid/ready target port) and the JK flop bank (J/K out, Q feedback in).

Parameters:
- W, 4: number of flops in the bank, and width of the target, J, K and q_fb.
- SETTLE, 1: idle cycles (J=K=0) between the drive cycle and the check; legal range 1..15.
- MAX_RETRY, 2: drive attempts after the first before an error is flagged; legal range 0..7.
- DC_FILL, 0: value placed on excitation don't-cares. 0 gives the set/reset style; 1 gives the toggle style.

Ports:
- CLK  in  1  Clock; all state updates on the rising edge.
- RST_n  in  1  Asynchronous reset, active low.
- tgt_valid  in  1  Target word offered.
- tgt_data  in  W  Target state for the bank.
- tgt_ready  out  1  Block accepts a target this cycle.
- J  out  W  J inputs to the bank; registered.
- K  out  W  K inputs to the bank; registered.
- q_fb  in  W  Q outputs of the bank; current state.
- done  out  1  One-cycle pulse: target reached.
- err  out  1  Sticky flag: retries exhausted. Cleared on the next accepted target.
- busy  out  1  High in any state other than IDLE.

Behaviour:
- Reset (async, while RST_n=0):
  - state=IDLE; J=0, K=0, done=0, err=0, busy=0, tgt_ready=1.
  - Internal target register, settle counter and retry counter all 0.
- Reset asserted mid-operation aborts immediately. J/K drop to 0, so the bank holds its state. No done pulse is issued.
- Handshake:
  - A target is accepted when tgt_valid and tgt_ready are both high on a rising edge. tgt_data is latched into tgt_q.
  - tgt_ready=1 only in IDLE, and it is registered.
  - tgt_valid while busy is ignored; the upstream side holds it.
- Excitation, per bit i, with q=q_fb[i] and t=tgt_q[i]:
  - DC_FILL=0: J=~q&t, K=q&~t.
  - DC_FILL=1: J=~q&t | q, K=q&~t | ~q. This equals J=K=q^t where q≠t, J=1,K=0 for 1→1, and J=0,K=1 for 0→0.
- State machine:
  - IDLE: on accept, go to DRIVE; err cleared; retry=0.
  - DRIVE: J/K register loaded with the excitation of the current q_fb. The bank updates on the next edge. Go to SETTLE; counter loaded with SETTLE.
  - SETTLE: J=K=0 (hold). Count down; at 1, go to CHECK.
  - CHECK:
    - If q_fb==tgt_q: done=1 for one cycle, go to IDLE.
    - Else if retry<MAX_RETRY: retry+1, go to DRIVE.
    - Else: err=1, go to IDLE, no done pulse.
- Latency: accept→done = 1 (DRIVE) + SETTLE + 1 (CHECK) cycles, plus 1 for the registered done. With SETTLE=1 that is 4 cycles.
- Target equal to current q_fb: still runs DRIVE (J/K encode hold/force per DC_FILL), then CHECK passes and done pulses.
- J and K are never both driven outside DRIVE. J=K=1 occurs only in DRIVE and only on differing bits when DC_FILL=1.

Optional Feature:
- Macro JK_FB_CHECK_EN.
- Defined: CHECK compares against q_fb and the retry/err path exists as described.
- Undefined:
  - No comparison: CHECK always pulses done.
  - err is tied to 0 and the retry counter is removed.
  - q_fb is still used for excitation.

Decomposition:
- Shared package jk_pkg holds:
  - state enum {IDLE, DRIVE, SETTLE, CHECK};
  - DC_FILL encodings JK_DC_ZERO=0 and JK_DC_ONE=1;
  - retry and settle counter widths.
- One sub-module, jk_excite: purely combinational. Inputs q, t (W bits); parameter DC_FILL; outputs j, k. It is reusable by the bench as a reference model.

Test Plan:
- W=4, DC_FILL=0, bank at 0000, target 1010 → the DRIVE cycle shows J=1010, K=0000. done pulses on cycle 4 after accept and q_fb=1010.
- DC_FILL=1, bank at 1100, target 1010 → DRIVE shows J=1110, K=0111. Bank ends at 1010; done pulses.
- JK_FB_CHECK_EN, q_fb forced stuck at 0000, target 0001, MAX_RETRY=2 → exactly 3 DRIVE cycles, err=1, no done, tgt_ready returns to 1. The next accept clears err.
- Target equal to current state, 0110 → done pulses after 4 cycles; bank value unchanged throughout.
- RST_n pulled low during SETTLE → J=K=0 immediately and no done; after release, tgt_ready=1 and busy=0.
- tgt_valid held high with a new value while busy → not latched. It is accepted only on the first IDLE cycle, and then processed correctly.
